// File: rtl/qdec_pkg.sv
// Shared types and the Gray-code transition decoder for quad_enc_decoder.
package qdec_pkg;

  typedef enum logic {S_INIT, S_TRACK} qdec_state_t;

  typedef logic [1:0] qphase_t;

  typedef enum logic [1:0] {D_NONE, D_UP, D_DOWN, D_ILLEGAL} qdec_move_t;

  // Phase word is {a,b}; clockwise order is 00 -> 10 -> 11 -> 01 -> 00.
  function automatic qdec_move_t qdec_decode(input qphase_t prev, input qphase_t cur);
    qdec_move_t m;
    m = D_DOWN;
    if (prev == cur) begin
      m = D_NONE;
    end else if ((prev ^ cur) == 2'b11) begin
      m = D_ILLEGAL;
    end else begin
      case ({prev, cur})
        4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: m = D_UP;
        default:                                m = D_DOWN;
      endcase
    end
    return m;
  endfunction

endpackage

// File: rtl/qdec_filter.sv
// Per-phase input conditioning: 2-flop synchroniser, plus a stability filter
// when QDEC_FILTER_EN is defined (output follows only after FILT_LEN equal samples).
module qdec_filter
`ifdef QDEC_FILTER_EN
  #(parameter int FILT_LEN = 4)
`endif
(
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic s1;
  logic s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= d;
      s2 <= s1;
    end
  end

`ifdef QDEC_FILTER_EN
  localparam int CW = $clog2(FILT_LEN);

  logic [CW-1:0] cnt;

  // cnt counts consecutive edges on which s2 disagrees with q; any agreement restarts it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      q   <= 1'b0;
    end else if (s2 == q) begin
      cnt <= '0;
    end else if (cnt == CW'(FILT_LEN - 1)) begin
      cnt <= '0;
      q   <= s2;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
`else
  assign q = s2;
`endif

endmodule

// File: rtl/quad_enc_decoder.sv
// Quadrature encoder receiver: conditioned A/B phases, settle FSM, step decode and
// wrapping position counter. Optional glitch filter enabled by QDEC_FILTER_EN.
module quad_enc_decoder
  import qdec_pkg::*;
#(
  parameter int CNT_W    = 16,
  parameter int FILT_LEN = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a,
  input  logic             b,
  input  logic             clr,
  output logic [CNT_W-1:0] count,
  output logic             step,
  output logic             dir,
  output logic             err
);

`ifdef QDEC_FILTER_EN
  localparam int SETTLE = 2 + FILT_LEN;
`else
  // FILT_LEN has no effect on timing without the filter.
  localparam int SETTLE = 2 + (FILT_LEN & 0);
`endif
  localparam int SC_W = $clog2(SETTLE + 1);

  logic        a_c;
  logic        b_c;
  qphase_t     cur;
  qphase_t     prev;
  qdec_state_t state;
  qdec_move_t  move;
  logic [SC_W-1:0] settle_cnt;

`ifdef QDEC_FILTER_EN
  qdec_filter #(.FILT_LEN(FILT_LEN)) u_filt_a (.clk(clk), .rst_n(rst_n), .d(a), .q(a_c));
  qdec_filter #(.FILT_LEN(FILT_LEN)) u_filt_b (.clk(clk), .rst_n(rst_n), .d(b), .q(b_c));
`else
  qdec_filter u_filt_a (.clk(clk), .rst_n(rst_n), .d(a), .q(a_c));
  qdec_filter u_filt_b (.clk(clk), .rst_n(rst_n), .d(b), .q(b_c));
`endif

  assign cur = {a_c, b_c};

  always_comb begin
    move = qdec_decode(prev, cur);
  end

  // prev follows cur in both states, so tracking starts from the phase present at settle end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_INIT;
      settle_cnt <= '0;
      prev       <= 2'b00;
      count      <= '0;
      step       <= 1'b0;
      dir        <= 1'b0;
      err        <= 1'b0;
    end else begin
      step <= 1'b0;
      err  <= 1'b0;
      prev <= cur;
      case (state)
        S_INIT: begin
          if (settle_cnt == SC_W'(SETTLE)) begin
            state <= S_TRACK;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        S_TRACK: begin
          case (move)
            D_UP: begin
              count <= count + CNT_W'(1);
              step  <= 1'b1;
              dir   <= 1'b1;
            end
            D_DOWN: begin
              count <= count - CNT_W'(1);
              step  <= 1'b1;
              dir   <= 1'b0;
            end
            D_ILLEGAL: err <= 1'b1;
            default: ;
          endcase
        end
        default: state <= S_INIT;
      endcase
      if (clr) begin
        count <= '0;
      end
    end
  end

endmodule
